// File: rtl/fios_pkg.sv
// Shared types and helpers for the FIOS operand loader and its storage banks.
package fios_pkg;

  localparam int WORD_W = 17;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_P,
    START,
    RUN
  } loader_state_t;

  // Circular increment over [0, lim-1].
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned lim);
    return (idx >= lim - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// s-word operand store: one write port, one registered read port (rdata follows raddr by one cycle).
// Reset clears only the read register; the array contents survive reset.
module operand_bank
  import fios_pkg::*;
#(
  parameter int s      = 8,
  parameter int WORD_W = 17
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 we,
  input  logic [$clog2(s)-1:0] waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [$clog2(s)-1:0] raddr,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [s];

  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) rdata <= '0;
    else         rdata <= mem[raddr];
  end

endmodule

// File: rtl/fios_operand_loader.sv
// Loads A, B, P operands from a valid/ready stream, then pulses start_o one cycle after the last P word
// and serves the multiplier's A window / B / P requests; in_ready_o is low from START until done_i.
module fios_operand_loader
  import fios_pkg::*;
#(
  parameter int s     = 8,
  parameter int PE_NB = 8
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  input  logic [WORD_W-1:0]         in_data_i,
  output logic                      in_ready_o,
  output logic                      start_o,
  output logic                      busy_o,
  input  logic                      a_shift_i,
  input  logic                      b_fetch_i,
  input  logic                      p_fetch_i,
  input  logic                      done_i,
  output logic [PE_NB*WORD_W-1:0]   a_o,
  output logic [WORD_W-1:0]         b_o,
  output logic [WORD_W-1:0]         p_o
);

  localparam int IDX_W = $clog2(s);
  localparam int AB_W  = $clog2(s + PE_NB);

  loader_state_t     state_q, state_d;
  logic [IDX_W-1:0]  load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]  b_idx_q, b_idx_d;
  logic [IDX_W-1:0]  p_idx_q, p_idx_d;
  logic [AB_W-1:0]   a_base_q, a_base_d;
  logic [AB_W-1:0]   a_idx;
  logic [WORD_W-1:0] a_mem [s];
  logic [PE_NB*WORD_W-1:0] a_win;
  logic              loading;
  logic              accept;
  int                a_sum;

  assign loading    = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_P);
  assign in_ready_o = !reset_i && loading;
  assign start_o    = !reset_i && (state_q == START);
  assign busy_o     = !reset_i && ((state_q == START) || (state_q == RUN));
  assign accept     = in_valid_i && in_ready_o;
  assign a_sum      = int'(a_base_q) + PE_NB;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    a_base_d   = a_base_q;
    b_idx_d    = b_idx_q;
    p_idx_d    = p_idx_q;
    case (state_q)
      LOAD_A, LOAD_B, LOAD_P: begin
        if (accept) begin
          if (load_cnt_q == IDX_W'(s - 1)) begin
            load_cnt_d = '0;
            case (state_q)
              LOAD_A:  state_d = LOAD_B;
              LOAD_B:  state_d = LOAD_P;
              default: state_d = START;
            endcase
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      START: state_d = RUN;
      RUN: begin
        // done_i overrides any advance request issued in the same cycle
        if (done_i) begin
          state_d  = LOAD_A;
          a_base_d = '0;
          b_idx_d  = '0;
          p_idx_d  = '0;
        end else begin
          if (a_shift_i) a_base_d = (a_sum >= s) ? '0 : AB_W'(a_sum);
          if (b_fetch_i) b_idx_d = IDX_W'(wrap_inc(int'(b_idx_q), s));
          if (p_fetch_i) p_idx_d = IDX_W'(wrap_inc(int'(p_idx_q), s));
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= LOAD_A;
      load_cnt_q <= '0;
      a_base_q   <= '0;
      b_idx_q    <= '0;
      p_idx_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      a_base_q   <= a_base_d;
      b_idx_q    <= b_idx_d;
      p_idx_q    <= p_idx_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (accept && (state_q == LOAD_A)) a_mem[load_cnt_q] <= in_data_i;
  end

  always_comb begin
    a_win = '0;
    a_idx = '0;
    for (int k = 0; k < PE_NB; k++) begin
      a_idx = a_base_q + AB_W'(k);
      if (a_idx < AB_W'(s)) a_win[k*WORD_W +: WORD_W] = a_mem[a_idx[IDX_W-1:0]];
    end
  end

  // Storage is not reset, so the window is masked until a loaded operand set is in use.
  assign a_o = busy_o ? a_win : '0;

  // Read ports follow the next-cycle pointer so a fetch is visible one cycle later.
  operand_bank #(.s(s), .WORD_W(WORD_W)) u_b_bank (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we      (accept && (state_q == LOAD_B)),
    .waddr   (load_cnt_q),
    .wdata   (in_data_i),
    .raddr   (b_idx_d),
    .rdata   (b_o)
  );

  operand_bank #(.s(s), .WORD_W(WORD_W)) u_p_bank (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we      (accept && (state_q == LOAD_P)),
    .waddr   (load_cnt_q),
    .wdata   (in_data_i),
    .raddr   (p_idx_d),
    .rdata   (p_o)
  );

endmodule

// File: tb/tb_fios_operand_loader.sv
// Bench for fios_operand_loader: two instances (PE_NB=8 and PE_NB=3) share one randomized stimulus
// and are compared every cycle against an operand-level reference model.
module tb_fios_operand_loader;

  localparam int S = 8;

  logic clock_i = 1'b0;
  logic reset_i, in_valid_i, a_shift_i, b_fetch_i, p_fetch_i, done_i;
  logic [16:0] in_data_i;

  logic         in_ready8, start8, busy8, in_ready3, start3, busy3;
  logic [135:0] a_o8;
  logic [50:0]  a_o3;
  logic [16:0]  b_o8, p_o8, b_o3, p_o3;

  always #5 clock_i = ~clock_i;

  fios_operand_loader #(.s(S), .PE_NB(8)) dut8 (
    .clock_i(clock_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready8), .start_o(start8), .busy_o(busy8), .a_shift_i(a_shift_i),
    .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i), .done_i(done_i),
    .a_o(a_o8), .b_o(b_o8), .p_o(p_o8)
  );

  fios_operand_loader #(.s(S), .PE_NB(3)) dut3 (
    .clock_i(clock_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready3), .start_o(start3), .busy_o(busy3), .a_shift_i(a_shift_i),
    .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i), .done_i(done_i),
    .a_o(a_o3), .b_o(b_o3), .p_o(p_o3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = start cycle, 2 = running.
  logic [16:0] ma [S];
  logic [16:0] mb [S];
  logic [16:0] mp [S];
  int m_phase = 0, m_cnt = 0, w8 = 0, w3 = 0, mbi = 0, mpi = 0;
  bit m_after_rst = 0, m_just_done = 0;
  int m_starts = 0, dut_starts = 0;
  logic [16:0] send_q[$];

  function automatic logic [135:0] exp_win(input int pe, input int w);
    logic [135:0] r;
    r = '0;
    for (int k = 0; k < pe; k++)
      if (w * pe + k < S) r[k*17 +: 17] = ma[w * pe + k];
    return r;
  endfunction

  task automatic tick(input bit rst, input bit sh, input bit bf, input bit pf, input bit dn,
                      input bit vrand);
    bit busy_e;
    reset_i = rst; a_shift_i = sh; b_fetch_i = bf; p_fetch_i = pf; done_i = dn;
    if (send_q.size() > 0) begin
      in_valid_i = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data_i  = send_q[0];
    end else if (m_phase != 0) begin
      in_valid_i = 1'($urandom_range(0, 1));
      in_data_i  = 17'($urandom);
    end else begin
      in_valid_i = 1'b0;
      in_data_i  = '0;
    end

    @(negedge clock_i);
    busy_e = !rst && (m_phase != 0);
    chk("in_ready8", 136'(in_ready8), 136'(!rst && m_phase == 0));
    chk("in_ready3", 136'(in_ready3), 136'(!rst && m_phase == 0));
    chk("start8", 136'(start8), 136'(!rst && m_phase == 1));
    chk("start3", 136'(start3), 136'(!rst && m_phase == 1));
    chk("busy8", 136'(busy8), 136'(busy_e));
    chk("busy3", 136'(busy3), 136'(busy_e));
    chk("a_o8", a_o8, busy_e ? exp_win(8, w8) : '0);
    chk("a_o3", 136'(a_o3), busy_e ? exp_win(3, w3) : '0);
    if (!rst && m_after_rst) begin
      chk("b_o_rst", 136'(b_o8), '0);
      chk("p_o_rst", 136'(p_o3), '0);
    end else if (!rst && (busy_e || m_just_done)) begin
      chk("b_o8", 136'(b_o8), 136'(mb[mbi]));
      chk("b_o3", 136'(b_o3), 136'(mb[mbi]));
      chk("p_o8", 136'(p_o8), 136'(mp[mpi]));
      chk("p_o3", 136'(p_o3), 136'(mp[mpi]));
    end
    if (start8) dut_starts++;

    @(posedge clock_i);
    m_just_done = 0;
    m_after_rst = 0;
    if (rst) begin
      m_phase = 0; m_cnt = 0; w8 = 0; w3 = 0; mbi = 0; mpi = 0;
      m_after_rst = 1;
    end else if (m_phase == 0) begin
      if (in_valid_i) begin
        if (m_cnt < S)          ma[m_cnt]       = in_data_i;
        else if (m_cnt < 2 * S) mb[m_cnt - S]   = in_data_i;
        else                    mp[m_cnt - 2*S] = in_data_i;
        void'(send_q.pop_front());
        m_cnt++;
        if (m_cnt == 3 * S) begin
          m_phase = 1; m_cnt = 0; m_starts++;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (dn) begin
      m_phase = 0; w8 = 0; w3 = 0; mbi = 0; mpi = 0; m_just_done = 1;
    end else begin
      if (sh) begin
        w8 = (w8 + 1) % ((S + 7) / 8);
        w3 = (w3 + 1) % ((S + 2) / 3);
      end
      if (bf) mbi = (mbi + 1) % S;
      if (pf) mpi = (mpi + 1) % S;
    end
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_rand();
    for (int i = 0; i < 3 * S; i++) send_q.push_back(17'($urandom));
  endtask

  task automatic load_all(input bit vrand);
    for (int i = 0; i < 400 && m_phase == 0; i++) tick(0, rb(), rb(), rb(), rb(), vrand);
    chk("load_timeout", 136'(m_phase != 0), 136'(1));
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) tick(0, rb(), rb(), rb(), 0, 1);
    tick(0, rb(), rb(), rb(), 1, 1);
  endtask

  initial begin
    reset_i = 1; in_valid_i = 0; in_data_i = '0;
    a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; done_i = 0;
    @(posedge clock_i); #1;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // directed load: A=1..8, B=11..18, P=21..28, valid held high
    for (int i = 0; i < S; i++) send_q.push_back(17'(i + 1));
    for (int i = 0; i < S; i++) send_q.push_back(17'(i + 11));
    for (int i = 0; i < S; i++) send_q.push_back(17'(i + 21));
    for (int i = 0; i < 100 && m_phase == 0; i++) tick(0, 0, 0, 0, 0, 0);
    chk("directed_load", 136'(m_phase), 136'(1));
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 1, 0);
    tick(0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      push_rand();
      load_all(1);
      run_random($urandom_range(4, 30));
    end

    // reset mid-load after 10 words, then a full reload
    push_rand();
    for (int i = 0; i < 200 && m_cnt < 10; i++) tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    send_q.delete();
    push_rand();
    load_all(1);
    run_random(12);
    tick(0, 0, 0, 0, 0, 0);

    chk("start_count", 136'(dut_starts), 136'(m_starts));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fios_operand_loader.md
Name: fios_operand_loader

Overview:
- Upstream operand stage of the cascaded FIOS multiplier.
- Accepts s-word operands A, B and P (17-bit words) over a valid/ready stream and stores them locally.
- Issues a single start pulse to the multiplier control.
- Serves the multiplier's operand requests:
  - parallel A window on a_o, advanced by a_shift_i;
  - B word on b_o, advanced by b_fetch_i;
  - P word on p_o, advanced by p_fetch_i.
- Returns to loading when the multiplier signals done_i.

Parameters:
- s, 8: number of 17-bit words per operand; s >= 2.
- PE_NB, 8: number of processing elements, which sets the width of the A window. 1 <= PE_NB <= s.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  input word valid
- in_data_i  in  17  input word; order is A[0..s-1], then B[0..s-1], then P[0..s-1], least significant word first
- in_ready_o  out  1  loader accepts a word this cycle
- start_o  out  1  one-cycle start pulse to the multiplier control
- busy_o  out  1  a multiplication is in flight (START or RUN state)
- a_shift_i  in  1  advance the A window
- b_fetch_i  in  1  advance the B pointer
- p_fetch_i  in  1  advance the P pointer
- done_i  in  1  multiplication complete
- a_o  out  PE_NB*17  A window; word k occupies bits [17k+16:17k]
- b_o  out  17  current B word
- p_o  out  17  current P word

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high on reset_i.
  - Reset forces state LOAD_A and clears load_cnt, a_base, b_idx and p_idx.
  - Output values during reset: in_ready_o=0, start_o=0, busy_o=0.
  - Output values in the cycle after reset: in_ready_o=1, start_o=0, busy_o=0, a_o, b_o and p_o all zero.
  - Operand storage is not cleared by reset.
- State machine (registered): LOAD_A, LOAD_B, LOAD_P, START, RUN.
  - LOAD_x: in_ready_o=1. A word is accepted when in_valid_i && in_ready_o; it is written to x[load_cnt] and load_cnt increments.
  - When load_cnt==s-1 and a word is accepted, load_cnt returns to 0 and the state advances LOAD_A -> LOAD_B -> LOAD_P -> START.
  - START: lasts exactly 1 cycle. start_o=1, busy_o=1, in_ready_o=0. Next state is RUN.
  - RUN: busy_o=1, in_ready_o=0. The state stays in RUN until done_i=1, then goes to LOAD_A and a_base, b_idx and p_idx return to 0.
- Latency: start_o is asserted in the cycle after the last P word is accepted.
- A window:
  - a_o word k = A[a_base+k] when a_base+k < s; otherwise 0.
  - In RUN, a_shift_i=1 sets a_base <= a_base+PE_NB. If a_base+PE_NB >= s, a_base wraps to 0.
  - When PE_NB==s, a_base stays at 0.
- B and P pointers:
  - b_o = B[b_idx] and p_o = P[p_idx], both registered array reads. The new word is visible in the cycle after the fetch pulse.
  - In RUN, b_fetch_i=1 sets b_idx <= (b_idx==s-1) ? 0 : b_idx+1. p_fetch_i behaves identically on p_idx.
  - b_fetch_i and p_fetch_i are independent and may be asserted in the same cycle.
- Boundary conditions:
  - a_shift_i, b_fetch_i and p_fetch_i are ignored outside RUN.
  - done_i is ignored outside RUN.
  - done_i together with any advance request in the same cycle: done_i wins and all pointers go to 0.
  - in_valid_i while in_ready_o=0: the word is not consumed; the producer must hold it.
  - Reset in any state, including mid-load or RUN: the partial load is discarded and no start_o is issued.
  - Pointer widths: load_cnt, b_idx and p_idx are $clog2(s) bits; a_base is $clog2(s+PE_NB) bits.

Decomposition:
- Package fios_pkg holds:
  - WORD_W=17;
  - enum loader_state_t {LOAD_A, LOAD_B, LOAD_P, START, RUN};
  - helper function for index wrap.
- Sub-module operand_bank (parameters s, WORD_W):
  - one write port: we, waddr, wdata;
  - one registered read port: raddr, rdata.
- operand_bank is instantiated for B and P.
- A uses a flat register array so the PE_NB-wide window can be read in parallel.

Test Plan:
- s=8, PE_NB=8. Load A=1..8, B=11..18, P=21..28 with valid held high:
  - in_ready_o drops after 24 accepted words;
  - start_o pulses exactly once, 1 cycle after word 24;
  - a_o words = 1..8.
- In RUN, pulse b_fetch_i 9 times: b_o sequence is 12,13,...,18,11,12 (wraps after 18).
- s=8, PE_NB=3, A=1..8. Pulse a_shift_i 3 times: a_o = {1,2,3} -> {4,5,6} -> {7,8,0} -> {1,2,3}.
- Randomly deassert in_valid_i during load, and assert in_valid_i during RUN:
  - stored words are unchanged;
  - no extra accepts occur in RUN;
  - busy_o stays high until done_i.
- Assert done_i and b_fetch_i in the same cycle:
  - next cycle state is LOAD_A, b_o=B[0], busy_o=0, in_ready_o=1.
- Assert reset_i after 10 words, then reload the full 24 words: no start_o until the full reload completes, and a_o reflects the new A.
